// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: flow-op encodings,
// return-stack command codes and the PC width.
package pc_seq_pkg;

  localparam int PC_W = 11;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_GOTO = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_SKIP = 3'd4,
    OP_RETI = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    STK_NOP = 2'd0,
    STK_PSH = 2'd1,
    STK_POP = 2'd2
  } stk_ctl_e;

  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a,
                                             input logic [1:0] n);
    return a + PC_W'(n);
  endfunction

endpackage

// File: rtl/pc_seq_stk_depth_mon.sv
// Return-stack occupancy tracker with saturating depth and sticky
// overflow/underflow flags, driven by push/pop strobes.
module stk_depth_mon #(
  parameter int STK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  output logic [2:0] depth,
  output logic       ovf,
  output logic       unf
);

  localparam logic [2:0] MAX_DEPTH = 3'(STK_DEPTH);

  logic [2:0] depth_q, depth_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  // A push at full depth still happens on the stack itself; only the count saturates.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push) begin
      if (depth_q == MAX_DEPTH) ovf_d = 1'b1;
      else                      depth_d = depth_q + 3'd1;
    end else if (pop) begin
      if (depth_q == 3'd0) unf_d = 1'b1;
      else                 depth_d = depth_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_q <= 3'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with call/return stack control and redirect flush.
// Define PC_INT_EN to enable the single-level interrupt (vector INT_VEC, RETI exit).
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [10:0] RST_VEC   = 11'h000,
  parameter logic [10:0] INT_VEC   = 11'h004,
  parameter int          STK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [10:0] tgt,
  input  logic        int_req,
  input  logic [10:0] stk_dout,
  output logic [10:0] pc,
  output logic [1:0]  stk_ctl,
  output logic [10:0] stk_din,
  output logic        flush,
  output logic [2:0]  depth,
  output logic        ovf,
  output logic        unf
);

  logic [10:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        push, pop;
  logic        int_acc;

`ifdef PC_INT_EN
  logic isr_q, isr_d;
  logic op_is_none;

  // Undefined encodings count as NONE, so they may also accept an interrupt.
  assign op_is_none = !(op inside {OP_GOTO, OP_CALL, OP_RET, OP_SKIP, OP_RETI});
  assign int_acc    = rst_n && en && int_req && !isr_q && op_is_none;

  always_comb begin
    isr_d = isr_q;
    if (int_acc)                    isr_d = 1'b1;
    else if (en && op == OP_RETI)   isr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) isr_q <= 1'b0;
    else        isr_q <= isr_d;
  end
`else
  logic int_unused;
  assign int_unused = int_req;
  assign int_acc    = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (en) begin
      case (op)
        OP_GOTO: begin
          pc_d    = tgt;
          flush_d = 1'b1;
        end
        OP_CALL: begin
          push    = 1'b1;
          pc_d    = tgt;
          flush_d = 1'b1;
        end
        OP_RET, OP_RETI: begin
          pop     = 1'b1;
          pc_d    = stk_dout;
          flush_d = 1'b1;
        end
        OP_SKIP: begin
          pc_d    = pc_add(pc_q, 2'd2);
          flush_d = 1'b1;
        end
        default: begin
          if (int_acc) begin
            push    = 1'b1;
            pc_d    = INT_VEC;
            flush_d = 1'b1;
          end else begin
            pc_d = pc_add(pc_q, 2'd1);
          end
        end
      endcase
    end
    // Reset must suppress stack traffic in the same cycle it is asserted.
    if (!rst_n) begin
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RST_VEC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc      = pc_q;
  assign flush   = flush_q;
  assign stk_din = pc_add(pc_q, 2'd1);
  assign stk_ctl = push ? STK_PSH : (pop ? STK_POP : STK_NOP);

  stk_depth_mon #(
    .STK_DEPTH(STK_DEPTH)
  ) u_depth_mon (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .depth(depth),
    .ovf  (ovf),
    .unf  (unf)
  );

endmodule
